// File: rtl/wb_queue.sv
// wb_queue : in-order writeback queue in front of the architectural register file.
//
// Accepts completed results from the LSU and the ALU through valid/ready
// handshakes. It buffers them as {rd, data} in a circular FIFO and drains one
// entry per cycle onto the register file write port.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : two read-stage lookup ports search the queued entries and
//               forward the youngest matching value.
//   undefined : no lookup ports. The read stage must wait for count == 0.
//
// Ports
//   clock, reset            sole clock; synchronous active-high reset
//   lsu_valid/ready/rd/data LSU result handshake (older of the two sources)
//   alu_valid/ready/rd/data ALU result handshake
//   write_params, data_rd   register file write request and data
//   count                   occupied entries
//   byp_rs{1,2}_addr/hit/data  read-stage forwarding (WB_BYPASS_EN only)

package wb_queue_pkg;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int REG_WIDTH      = 32;

   typedef logic [REG_WIDTH-1:0] arch_reg;

   typedef struct packed {
      logic                      write_enable;
      logic [REG_ADDR_WIDTH-1:0] addr_rd;
   } reg_file_write_params_t;
endpackage

module wb_queue
   import wb_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         lsu_valid,
   output logic                         lsu_ready,
   input  logic [REG_ADDR_WIDTH-1:0]    lsu_rd,
   input  logic [REG_WIDTH-1:0]         lsu_data,
   input  logic                         alu_valid,
   output logic                         alu_ready,
   input  logic [REG_ADDR_WIDTH-1:0]    alu_rd,
   input  logic [REG_WIDTH-1:0]         alu_data,
   output reg_file_write_params_t       write_params,
   output arch_reg                      data_rd,
   output logic [$clog2(DEPTH):0]       count
`ifdef WB_BYPASS_EN
   ,
   input  logic [REG_ADDR_WIDTH-1:0]    byp_rs1_addr,
   input  logic [REG_ADDR_WIDTH-1:0]    byp_rs2_addr,
   output logic                         byp_rs1_hit,
   output logic                         byp_rs2_hit,
   output logic [REG_WIDTH-1:0]         byp_rs1_data,
   output logic [REG_WIDTH-1:0]         byp_rs2_data
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0] rd;
      arch_reg                   data;
   } entry_t;

   entry_t             mem_q [DEPTH];
   entry_t             mem_d [DEPTH];
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic               lsu_store;
   logic               alu_store;
   logic               pop;
   logic [1:0]         n_push;
   logic [PTR_W-1:0]   alu_slot;
   entry_t             head_entry;

   // Ready depends on registered occupancy only. The ALU needs headroom for a
   // simultaneous LSU push, so it stalls one entry earlier.
   always_comb begin
      lsu_ready = (count_q <= CNT_W'(DEPTH - 1));
      alu_ready = (count_q <= CNT_W'(DEPTH - 2));
   end

   // Writes to x0 complete the handshake but are dropped.
   always_comb begin
      lsu_store = lsu_valid && lsu_ready && (lsu_rd != '0);
      alu_store = alu_valid && alu_ready && (alu_rd != '0);
      pop       = (count_q != '0);
      n_push    = {1'b0, lsu_store} + {1'b0, alu_store};
   end

   always_comb begin
      mem_d    = mem_q;
      alu_slot = tail_q + PTR_W'(lsu_store);
      if (lsu_store) begin
         mem_d[tail_q] = '{rd: lsu_rd, data: lsu_data};
      end
      if (alu_store) begin
         mem_d[alu_slot] = '{rd: alu_rd, data: alu_data};
      end
      tail_d  = tail_q + PTR_W'(n_push);
      head_d  = pop ? (head_q + PTR_W'(1)) : head_q;
      count_d = count_q + CNT_W'(n_push) - CNT_W'(pop);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Write port: head entry whenever the queue is occupied. Stale storage is
   // masked when empty.
   always_comb begin
      head_entry                = mem_q[head_q];
      write_params.write_enable = pop;
      write_params.addr_rd      = pop ? head_entry.rd   : '0;
      data_rd                   = pop ? head_entry.data : '0;
      count                     = count_q;
   end

`ifdef WB_BYPASS_EN
   logic [PTR_W-1:0] byp_idx;

   // Walk from head (oldest) to tail (youngest). A later match overrides an
   // earlier one, so the youngest value wins. The head entry being written
   // this cycle is included.
   always_comb begin
      byp_rs1_hit  = 1'b0;
      byp_rs2_hit  = 1'b0;
      byp_rs1_data = '0;
      byp_rs2_data = '0;
      byp_idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         byp_idx = head_q + PTR_W'(i);
         if (count_q > CNT_W'(i)) begin
            if ((byp_rs1_addr != '0) && (mem_q[byp_idx].rd == byp_rs1_addr)) begin
               byp_rs1_hit  = 1'b1;
               byp_rs1_data = mem_q[byp_idx].data;
            end
            if ((byp_rs2_addr != '0) && (mem_q[byp_idx].rd == byp_rs2_addr)) begin
               byp_rs2_hit  = 1'b1;
               byp_rs2_data = mem_q[byp_idx].data;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_wb_queue.sv
module tb_wb_queue;
   import wb_queue_pkg::*;

   localparam int DEPTH = 4;

   logic                      clock = 1'b0;
   logic                      reset;
   logic                      lsu_valid, alu_valid;
   logic                      lsu_ready, alu_ready;
   logic [REG_ADDR_WIDTH-1:0] lsu_rd, alu_rd;
   logic [REG_WIDTH-1:0]      lsu_data, alu_data;
   reg_file_write_params_t    write_params;
   arch_reg                   data_rd;
   logic [$clog2(DEPTH):0]    count;
`ifdef WB_BYPASS_EN
   logic [REG_ADDR_WIDTH-1:0] byp_rs1_addr, byp_rs2_addr;
   logic                      byp_rs1_hit, byp_rs2_hit;
   logic [REG_WIDTH-1:0]      byp_rs1_data, byp_rs2_data;
`endif

   wb_queue #(.DEPTH(DEPTH)) dut (
      .clock        (clock),
      .reset        (reset),
      .lsu_valid    (lsu_valid),
      .lsu_ready    (lsu_ready),
      .lsu_rd       (lsu_rd),
      .lsu_data     (lsu_data),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .write_params (write_params),
      .data_rd      (data_rd),
      .count        (count)
`ifdef WB_BYPASS_EN
      ,
      .byp_rs1_addr (byp_rs1_addr),
      .byp_rs2_addr (byp_rs2_addr),
      .byp_rs1_hit  (byp_rs1_hit),
      .byp_rs2_hit  (byp_rs2_hit),
      .byp_rs1_data (byp_rs1_data),
      .byp_rs2_data (byp_rs2_data)
`endif
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic [REG_WIDTH-1:0]      data;
   } exp_t;

   exp_t exp_q[$];
   int   model_cnt = 0;
   int   checks = 0;
   int   errors = 0;
   bit   lsu_xfer, alu_xfer;
   bit   mon_en = 1'b0;
   bit   saw_alu_stall = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: decides transfers from its own occupancy and pushes the
   // expected writes in age order (LSU before ALU).
   always @(posedge clock) begin : model
      int n;
      lsu_xfer = 1'b0;
      alu_xfer = 1'b0;
      if (reset) begin
         model_cnt = 0;
         exp_q.delete();
      end else begin
         n = 0;
         lsu_xfer = lsu_valid && (model_cnt <= DEPTH - 1);
         alu_xfer = alu_valid && (model_cnt <= DEPTH - 2);
         if (lsu_xfer && lsu_rd != 0) begin
            exp_q.push_back('{rd: lsu_rd, data: lsu_data});
            n++;
         end
         if (alu_xfer && alu_rd != 0) begin
            exp_q.push_back('{rd: alu_rd, data: alu_data});
            n++;
         end
         model_cnt = model_cnt + n - ((model_cnt != 0) ? 1 : 0);
      end
   end

   // Monitor: compares the write port against the scoreboard every cycle.
   always @(negedge clock) begin : monitor
      exp_t e;
      if (mon_en) begin
         chk("count", 64'(count), 64'(model_cnt));
         chk("lsu_ready", 64'(lsu_ready), 64'(model_cnt <= DEPTH - 1));
         chk("alu_ready", 64'(alu_ready), 64'(model_cnt <= DEPTH - 2));
         chk("write_enable", 64'(write_params.write_enable), 64'(model_cnt != 0));
         if (count == 3 && !alu_ready && lsu_ready) saw_alu_stall = 1'b1;
         if (write_params.write_enable && !reset) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write",
                        write_params.addr_rd, data_rd);
            end else begin
               e = exp_q.pop_front();
               chk("addr_rd", 64'(write_params.addr_rd), 64'(e.rd));
               chk("data_rd", 64'(data_rd), 64'(e.data));
            end
         end else if (!write_params.write_enable) begin
            chk("idle_addr_rd", 64'(write_params.addr_rd), 64'd0);
            chk("idle_data_rd", 64'(data_rd), 64'd0);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      lsu_valid = 1'b0;
      alu_valid = 1'b0;
      lsu_rd    = '0;
      alu_rd    = '0;
      lsu_data  = '0;
      alu_data  = '0;
   endtask

   initial begin : stim
      int guard;
      int lsu_k, alu_k;
      reset = 1'b1;
      idle_inputs();
`ifdef WB_BYPASS_EN
      byp_rs1_addr = '0;
      byp_rs2_addr = '0;
`endif
      repeat (2) @(posedge clock);
      #1;
      reset  = 1'b0;
      @(negedge clock);
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_we", 64'(write_params.write_enable), 64'd0);
      mon_en = 1'b1;
      step();

      // Single ALU push
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1234_5678;
      step();
      idle_inputs();
      @(negedge clock);
      chk("single_we_n1", 64'(write_params.write_enable), 64'd1);
      chk("single_rd_n1", 64'(write_params.addr_rd), 64'd3);
      chk("single_data_n1", 64'(data_rd), 64'h1234_5678);
      step();
      @(negedge clock);
      chk("single_we_n2", 64'(write_params.write_enable), 64'd0);
      step();

      // Dual push: LSU older
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h11;
      alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h22;
      step();
      idle_inputs();
      @(negedge clock);
      chk("dual_count2", 64'(count), 64'd2);
      chk("dual_rd7", 64'(write_params.addr_rd), 64'd7);
      step();
      @(negedge clock);
      chk("dual_count1", 64'(count), 64'd1);
      chk("dual_rd8", 64'(write_params.addr_rd), 64'd8);
      chk("dual_data22", 64'(data_rd), 64'h22);
      step();
      @(negedge clock);
      chk("dual_count0", 64'(count), 64'd0);
      step();

      // x0 filter
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
      chk("x0_alu_ready", 64'(alu_ready), 64'd1);
      step();
      idle_inputs();
      @(negedge clock);
      chk("x0_count", 64'(count), 64'd0);
      chk("x0_we", 64'(write_params.write_enable), 64'd0);
      step();

      // LSU to x0 with ALU real: ALU must land at tail
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hDEAD_BEEF;
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
      step();
      idle_inputs();
      @(negedge clock);
      chk("x0lsu_count", 64'(count), 64'd1);
      chk("x0lsu_rd", 64'(write_params.addr_rd), 64'd4);
      chk("x0lsu_data", 64'(data_rd), 64'h44);
      step();

      // Reset mid-drain
      lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'hAAAA_0001;
      alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'hAAAA_0002;
      step();
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clock);
      chk("rst_mid_count", 64'(count), 64'd0);
      chk("rst_mid_we", 64'(write_params.write_enable), 64'd0);
      step();

      // Fill / back-pressure, 10 entries across pointer wrap
      lsu_k = 0;
      alu_k = 0;
      guard = 0;
      while ((lsu_k < 5 || alu_k < 5) && guard < 100) begin
         lsu_valid = (lsu_k < 5);
         lsu_rd    = 5'(10 + 2 * lsu_k);
         lsu_data  = 32'hC0DE_0000 | 32'(lsu_k);
         alu_valid = (alu_k < 5);
         alu_rd    = 5'(11 + 2 * alu_k);
         alu_data  = 32'hA100_0000 | 32'(alu_k);
         step();
         if (lsu_xfer) lsu_k++;
         if (alu_xfer) alu_k++;
         guard++;
      end
      idle_inputs();
      chk("fill_done_in_budget", 64'(guard < 100), 64'd1);
      chk("fill_alu_stall_seen", 64'(saw_alu_stall), 64'd1);
      repeat (6) step();
      @(negedge clock);
      chk("fill_drained_count", 64'(count), 64'd0);
      chk("fill_scoreboard_empty", 64'(exp_q.size()), 64'd0);
      step();

`ifdef WB_BYPASS_EN
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h100;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h200;
      step();
      idle_inputs();
      byp_rs1_addr = 5'd9;
      byp_rs2_addr = 5'd0;
      @(negedge clock);
      chk("byp_rs1_hit", 64'(byp_rs1_hit), 64'd1);
      chk("byp_rs1_data", 64'(byp_rs1_data), 64'h200);
      chk("byp_rs2_hit", 64'(byp_rs2_hit), 64'd0);
      repeat (3) step();
`endif

      @(negedge clock);
      chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
